jtframe_dwnld_banks: RTL and testbench
======================================

Name: jtframe_dwnld_banks

Overview:
- Parametrised download router between the ioctl byte stream and the SDRAM programming port.
- Successor to the fixed single-bank prog_* path.
- Splits the incoming ROM into up to 4 SDRAM banks plus a PROM region, packs byte offsets into word addresses and masks, and buffers writes in a FIFO so that slow sdram_ack never drops bytes.
- Sits between the ioctl interface and the SDRAM controller's programming port.

Parameters:
- BANKS, 1: number of SDRAM banks used (1..4); banks at index BANKS or higher are never selected.
- BA1_START, 25'h10_0000: ioctl byte address where bank 1 begins.
- BA2_START, 25'h20_0000: ioctl byte address where bank 2 begins.
- BA3_START, 25'h30_0000: ioctl byte address where bank 3 begins.
- PROM_START, 25'h1FF_FFFF: first ioctl address routed to the PROM port; the default means unused.
- AW, 22: SDRAM word address width.
- FIFO_AW, 2: log2 of FIFO depth (depth = 4 by default).
- SWAB, 0: when 1, invert byte lane selection.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- downloading  in  1  high while the ioctl transfer is active
- ioctl_addr  in  25  byte address of the current ioctl byte
- ioctl_data  in  8  data byte
- ioctl_wr  in  1  one-cycle strobe, byte valid
- prog_addr  out  AW  word address within the bank
- prog_data  out  16  byte duplicated on both lanes
- prog_mask  out  2  active-low lane mask
- prog_bank  out  2  target bank
- prog_we  out  1  write request, held until ack
- sdram_ack  in  1  one-cycle acceptance of the current request
- prom_we  out  1  one-cycle PROM write pulse
- prom_addr  out  10  PROM byte offset
- prom_data  out  8  PROM data byte
- dwnld_busy  out  1  transfer or FIFO drain in progress
- overflow  out  1  sticky, a byte was dropped

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0 and the FIFO is emptied.
  - Reset mid-transfer discards all queued entries; no prog_we glitch.
- Region decode on ioctl_wr, with priority PROM > bank3 > bank2 > bank1 > bank0:
  - ioctl_addr >= PROM_START selects the PROM region.
  - Otherwise the highest bank with index < BANKS and ioctl_addr >= its start is selected.
  - Bank 0 starts at 0.
  - The PROM check is registered one cycle.
- Offset = ioctl_addr - bank start, 25-bit unsigned.
  - prog_addr = offset[AW:1]; upper bits are truncated and wrap silently.
- Lane: lane = offset[0] ^ SWAB.
  - lane 0: prog_mask = 2'b10 (low byte written).
  - lane 1: prog_mask = 2'b01.
- prog_data = {ioctl_data, ioctl_data}.
- PROM path:
  - prom_we pulses high exactly 1 cycle after ioctl_wr.
  - prom_addr = (ioctl_addr - PROM_START)[9:0] and prom_data = ioctl_data, valid in the same cycle.
  - The PROM path is not queued in the FIFO.
- FIFO: each SDRAM-bound byte pushes {bank, addr, mask, data}; depth is 2^FIFO_AW.
  - Full with no pop in the same cycle: the byte is dropped and overflow is set.
  - Full with a pop in the same cycle: the push is accepted.
- Output handshake:
  - prog_we = FIFO not empty.
  - The head entry drives prog_addr, prog_data, prog_mask and prog_bank, which stay stable while prog_we is high and no ack has arrived.
  - sdram_ack while prog_we is high pops the head. The next entry appears on the following cycle with prog_we still high, and prog_we deasserts once the FIFO is empty.
  - sdram_ack while prog_we is low is ignored.
  - Latency from ioctl_wr to prog_we is 1 cycle when the FIFO is empty.
- dwnld_busy = downloading | prog_we.
  - It stays high after downloading falls until the FIFO drains, then drops the next cycle.
- overflow is cleared on the rising edge of downloading and otherwise holds its value.
- ioctl_wr while downloading is low is ignored.

Optional Feature:
- Macro: JTFRAME_DWNLD_HEADER_EN.
- Defined:
  - Adds parameter HEADER (default 32) and output header_data (8) with header_we (1).
  - The first HEADER bytes of a transfer (ioctl_addr < HEADER) go to header_we/header_data as 1-cycle pulses and are not sent to SDRAM or PROM.
  - All region decoding uses ioctl_addr - HEADER.
- Undefined: no header ports exist; addresses are decoded directly.

Test Plan:
- BANKS=1, write bytes 0x11 at addr 0 and 0x22 at addr 1, ack 3 cycles after each prog_we -> prog_addr 0, mask 10, data 1111; then prog_addr 0, mask 01, data 2222; dwnld_busy falls after the last ack once downloading is low.
- BANKS=4, write at 0x10_0004, 0x20_0006, 0x30_0009 -> prog_bank 1/2/3, prog_addr 2/3/4, masks 10/10/01.
- BANKS=2, write at 0x30_0000 -> bank 1, prog_addr 0x10_0000.
- PROM_START=0x40_0000, write 0x5A at 0x40_0003 -> prom_we 1 cycle later with prom_addr 3 and prom_data 5A; prog_we stays low.
- FIFO_AW=2, sdram_ack held low, 6 strobes -> 4 entries queued and overflow=1; release acks -> 4 writes in order; a new downloading rise clears overflow.
- rst_n low with 3 entries queued -> prog_we=0 immediately, asynchronously; after release, no stale writes appear.

Source files
------------

// File: rtl/jtframe_dwnld_banks_if.sv
// SDRAM programming port bundle between the download router and the SDRAM
// controller.
//   master : router side, drives the write request and its payload
//   slave  : SDRAM controller side, returns the one-cycle acceptance
// Signals:
//   prog_addr  word address within the bank (AW bits)
//   prog_data  byte duplicated on both lanes
//   prog_mask  active-low lane mask
//   prog_bank  target SDRAM bank
//   prog_we    write request, held until sdram_ack
//   sdram_ack  one-cycle acceptance of the current request
interface jtframe_dwnld_banks_if #(
  parameter int AW = 22
);
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic [1:0]    prog_bank;
  logic          prog_we;
  logic          sdram_ack;

  modport master (
    output prog_addr, prog_data, prog_mask, prog_bank, prog_we,
    input  sdram_ack
  );

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_bank, prog_we,
    output sdram_ack
  );
endinterface

// File: rtl/jtframe_dwnld_banks.sv
// Download router: splits the ioctl byte stream into up to four SDRAM banks
// plus a PROM region. SDRAM-bound bytes are packed into word address + lane
// mask and queued in a small FIFO so a slow sdram_ack never loses data;
// PROM bytes bypass the FIFO as a registered one-cycle pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   downloading         ioctl transfer active
//   ioctl_addr/data/wr  incoming byte stream (wr is a one-cycle strobe)
//   prog (master)       SDRAM programming port, see jtframe_dwnld_banks_if
//   prom_we/addr/data   PROM write pulse, byte offset and data
//   dwnld_busy          transfer or FIFO drain in progress
//   overflow            sticky: a byte was dropped on a full FIFO,
//                       cleared when downloading rises
// Optional build macro JTFRAME_DWNLD_HEADER_EN: adds parameter HEADER and
// outputs header_we/header_data. The first HEADER bytes of a transfer are
// diverted there and every region decode uses ioctl_addr - HEADER.
module jtframe_dwnld_banks #(
  parameter int          BANKS      = 1,
  parameter logic [24:0] BA1_START  = 25'h10_0000,
  parameter logic [24:0] BA2_START  = 25'h20_0000,
  parameter logic [24:0] BA3_START  = 25'h30_0000,
  parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
  parameter int          AW         = 22,
  parameter int          FIFO_AW    = 2,
  parameter int          SWAB       = 0
`ifdef JTFRAME_DWNLD_HEADER_EN
  , parameter int        HEADER     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  jtframe_dwnld_banks_if.master prog,
  output logic                  prom_we,
  output logic [9:0]            prom_addr,
  output logic [7:0]            prom_data,
  output logic                  dwnld_busy,
  output logic                  overflow
`ifdef JTFRAME_DWNLD_HEADER_EN
  , output logic                header_we,
  output logic [7:0]            header_data
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  // FIFO entry: {bank, word address, mask, data byte}
  localparam int EW    = 2 + AW + 2 + 8;

  logic [24:0]        addr_eff;
  logic [24:0]        bank_start;
  logic [AW:0]        offset;
  logic [9:0]         prom_off;
  logic [1:0]         bank_sel;
  logic [1:0]         mask;
  logic               hdr_sel;
  logic               prom_sel;
  logic               lane;

  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      head;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty;
  logic               full;
  logic               wr_fire;
  logic               push;
  logic               pop;
  logic               drop;
  logic               downloading_p1;

`ifdef JTFRAME_DWNLD_HEADER_EN
  localparam logic [24:0] HDR_LEN = 25'(HEADER);
  assign hdr_sel  = ioctl_addr < HDR_LEN;
  assign addr_eff = ioctl_addr - HDR_LEN;
`else
  assign hdr_sel  = 1'b0;
  assign addr_eff = ioctl_addr;
`endif

  // ---- stage p0: region decode and word packing (combinational) ----
  // Checked from the highest bank down so the first match wins; banks at or
  // above BANKS are excluded by the constant BANKS test.
  always_comb begin
    bank_sel   = 2'd0;
    bank_start = '0;
    if (BANKS > 3 && addr_eff >= BA3_START) begin
      bank_sel   = 2'd3;
      bank_start = BA3_START;
    end else if (BANKS > 2 && addr_eff >= BA2_START) begin
      bank_sel   = 2'd2;
      bank_start = BA2_START;
    end else if (BANKS > 1 && addr_eff >= BA1_START) begin
      bank_sel   = 2'd1;
      bank_start = BA1_START;
    end
  end

  assign prom_sel = addr_eff >= PROM_START;
  // Only bits [AW:0] of the offset matter; higher bits wrap silently.
  assign offset   = (AW+1)'(addr_eff - bank_start);
  assign prom_off = 10'(addr_eff - PROM_START);
  assign lane     = offset[0] ^ (SWAB != 0);
  assign mask     = lane ? 2'b01 : 2'b10;

  assign empty   = count == '0;
  assign full    = count == (FIFO_AW+1)'(DEPTH);
  assign wr_fire = ioctl_wr & downloading & ~hdr_sel;
  assign pop     = prog.sdram_ack & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = wr_fire & ~prom_sel & (~full | pop);
  assign drop    = wr_fire & ~prom_sel & full & ~pop;

  // ---- stage p1: FIFO storage, PROM pulse, status ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bank_sel, offset[AW:1], mask, ioctl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      downloading_p1 <= 1'b0;
      overflow       <= 1'b0;
      prom_we        <= 1'b0;
      prom_addr      <= '0;
      prom_data      <= '0;
    end else begin
      downloading_p1 <= downloading;
      // A drop in the very cycle of a new transfer start still counts.
      if (drop)
        overflow <= 1'b1;
      else if (downloading & ~downloading_p1)
        overflow <= 1'b0;
      prom_we <= wr_fire & prom_sel;
      if (wr_fire & prom_sel) begin
        prom_addr <= prom_off;
        prom_data <= ioctl_data;
      end
    end
  end

`ifdef JTFRAME_DWNLD_HEADER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_we   <= 1'b0;
      header_data <= '0;
    end else begin
      header_we <= ioctl_wr & downloading & hdr_sel;
      if (ioctl_wr & downloading & hdr_sel) header_data <= ioctl_data;
    end
  end
`endif

  // ---- output: FIFO head drives the programming port ----
  // Head is forced to zero when empty so a discarded queue never shows
  // stale payload after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_comb begin
    prog.prog_we   = ~empty;
    prog.prog_bank = head[EW-1 -: 2];
    prog.prog_addr = head[AW+9 : 10];
    prog.prog_mask = head[9:8];
    prog.prog_data = {head[7:0], head[7:0]};
  end

  assign dwnld_busy = rst_n & (downloading | ~empty);

endmodule

// File: tb/tb_jtframe_dwnld_banks.sv
`timescale 1ns/1ps
module tb_jtframe_dwnld_banks;

  localparam int          BANKS   = 3;
  localparam int          AW      = 22;
  localparam int          FIFO_AW = 2;
  localparam int          DEPTH   = 4;
  localparam int          SWAB    = 0;
  localparam logic [24:0] BA1     = 25'h10_0000;
  localparam logic [24:0] BA2     = 25'h20_0000;
  localparam logic [24:0] BA3     = 25'h30_0000;
  localparam logic [24:0] PROM    = 25'h40_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prom_we;
  logic [9:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;

  jtframe_dwnld_banks_if #(.AW(AW)) prog_if ();

  jtframe_dwnld_banks #(
    .BANKS(BANKS), .BA1_START(BA1), .BA2_START(BA2), .BA3_START(BA3),
    .PROM_START(PROM), .AW(AW), .FIFO_AW(FIFO_AW), .SWAB(SWAB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog(prog_if),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ack driver ----------------
  int   ack_mode  = 0;   // 0: follow ack_force, 1: random
  logic ack_force = 1'b0;
  initial begin
    prog_if.sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      prog_if.sdram_ack = (ack_mode == 1) ? ($urandom_range(0, 1) == 0) : ack_force;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    bank;
    logic [AW-1:0] addr;
    logic [1:0]    mask;
    logic [7:0]    data;
  } ent_t;

  ent_t       mq[$];
  bit         m_ovf = 0;
  bit         m_prom_we = 0;
  bit         m_dl = 0;
  logic [9:0] m_prom_addr = '0;
  logic [7:0] m_prom_data = '0;
  bit         m_wr, m_pop, m_isp;
  ent_t       m_ent;
  logic [9:0] m_poff;

  // Route one byte by the region rules: PROM above PROM_START, otherwise the
  // highest-index enabled bank whose start is not above the address.
  function automatic void ref_route(input logic [24:0] a, input logic [7:0] d,
                                    output bit is_prom, output ent_t e,
                                    output logic [9:0] poff);
    logic [24:0] starts [4];
    logic [24:0] off;
    logic [24:0] pdiff;
    int b;
    starts[0] = 25'd0; starts[1] = BA1; starts[2] = BA2; starts[3] = BA3;
    b = 0;
    for (int i = 1; i < BANKS; i++)
      if (a >= starts[i]) b = i;
    off     = a - starts[b];
    is_prom = (a >= PROM);
    e.bank  = 2'(b);
    e.addr  = AW'(off / 2);
    e.mask  = (((off % 2) == 1) != (SWAB != 0)) ? 2'b01 : 2'b10;
    e.data  = d;
    pdiff   = a - PROM;
    poff    = pdiff[9:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_prom_we = 0; m_dl = 0;
      m_prom_addr = '0; m_prom_data = '0;
    end else begin
      m_wr  = ioctl_wr && downloading;
      m_pop = prog_if.sdram_ack && (mq.size() != 0);
      ref_route(ioctl_addr, ioctl_data, m_isp, m_ent, m_poff);
      if (downloading && !m_dl) m_ovf = 0;
      m_prom_we = m_wr && m_isp;
      if (m_prom_we) begin
        m_prom_addr = m_poff;
        m_prom_data = ioctl_data;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_wr && !m_isp) begin
        if (mq.size() < DEPTH) mq.push_back(m_ent);
        else m_ovf = 1;
      end
      m_dl = downloading;
    end
  end

  // Per-cycle comparison against the model, sampled mid-low-phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("m_prog_we", prog_if.prog_we, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_prog_bank", prog_if.prog_bank, mq[0].bank);
        chk("m_prog_addr", prog_if.prog_addr, mq[0].addr);
        chk("m_prog_mask", prog_if.prog_mask, mq[0].mask);
        chk("m_prog_data", prog_if.prog_data, {mq[0].data, mq[0].data});
      end
      chk("m_prom_we", prom_we, m_prom_we);
      if (m_prom_we) begin
        chk("m_prom_addr", prom_addr, m_prom_addr);
        chk("m_prom_data", prom_data, m_prom_data);
      end
      chk("m_overflow", overflow, m_ovf);
      chk("m_busy", dwnld_busy, rst_n && (downloading || mq.size() != 0));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        is_prom;
    logic [1:0]  bank;
    logic [21:0] waddr;
    logic [1:0]  mask;
    logic [9:0]  paddr;
  } vec_t;

  initial begin
    vec_t tbl [12];
    int   cyc;
    tbl[0]  = '{25'h000000, 8'h11, 1'b0, 2'd0, 22'h000000, 2'b10, 10'h0};
    tbl[1]  = '{25'h000001, 8'h22, 1'b0, 2'd0, 22'h000000, 2'b01, 10'h0};
    tbl[2]  = '{25'h100004, 8'h33, 1'b0, 2'd1, 22'h000002, 2'b10, 10'h0};
    tbl[3]  = '{25'h200006, 8'h44, 1'b0, 2'd2, 22'h000003, 2'b10, 10'h0};
    tbl[4]  = '{25'h300009, 8'h55, 1'b0, 2'd2, 22'h080004, 2'b01, 10'h0};
    tbl[5]  = '{25'h0FFFFF, 8'h66, 1'b0, 2'd0, 22'h07FFFF, 2'b01, 10'h0};
    tbl[6]  = '{25'h3FFFFF, 8'h77, 1'b0, 2'd2, 22'h0FFFFF, 2'b01, 10'h0};
    tbl[7]  = '{25'h400003, 8'h5A, 1'b1, 2'd0, 22'h000000, 2'b00, 10'h003};
    tbl[8]  = '{25'h400000, 8'hA5, 1'b1, 2'd0, 22'h000000, 2'b00, 10'h000};
    tbl[9]  = '{25'h7FFFFE, 8'h99, 1'b1, 2'd0, 22'h000000, 2'b00, 10'h3FE};
    tbl[10] = '{25'h1FFFFF, 8'h88, 1'b0, 2'd1, 22'h07FFFF, 2'b01, 10'h0};
    tbl[11] = '{25'h200000, 8'hBB, 1'b0, 2'd2, 22'h000000, 2'b10, 10'h0};

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_prog_we", prog_if.prog_we, 1'b0);
    chk("rst_prog_addr", prog_if.prog_addr, 22'h0);
    chk("rst_prog_mask", prog_if.prog_mask, 2'b00);
    chk("rst_prom_we", prom_we, 1'b0);
    chk("rst_prom_addr", prom_addr, 10'h0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", dwnld_busy, 1'b0);
    rst_n = 1'b1;
    downloading = 1'b1;

    // table: one byte each, ack three cycles after prog_we rises
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ioctl_addr = tbl[i].addr; ioctl_data = tbl[i].data; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (tbl[i].is_prom) begin
        chk("tbl_prom_we", prom_we, 1'b1);
        chk("tbl_prom_addr", prom_addr, tbl[i].paddr);
        chk("tbl_prom_data", prom_data, tbl[i].data);
        chk("tbl_prom_no_prog", prog_if.prog_we, 1'b0);
        @(negedge clk);
        chk("tbl_prom_pulse", prom_we, 1'b0);
      end else begin
        chk("tbl_prog_we", prog_if.prog_we, 1'b1);
        chk("tbl_prog_bank", prog_if.prog_bank, tbl[i].bank);
        chk("tbl_prog_addr", prog_if.prog_addr, tbl[i].waddr);
        chk("tbl_prog_mask", prog_if.prog_mask, tbl[i].mask);
        chk("tbl_prog_data", prog_if.prog_data, {tbl[i].data, tbl[i].data});
        repeat (2) @(negedge clk);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        chk("tbl_prog_done", prog_if.prog_we, 1'b0);
      end
    end

    // busy stays up after downloading falls until the drain completes
    @(negedge clk);
    ioctl_addr = 25'h10; ioctl_data = 8'h3C; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0; downloading = 1'b0;
    @(negedge clk);
    chk("tail_busy_hi", dwnld_busy, 1'b1);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    chk("tail_busy_lo", dwnld_busy, 1'b0);
    chk("tail_prog_we", prog_if.prog_we, 1'b0);

    // overflow: six strobes with ack low, four kept in order
    downloading = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ioctl_addr = 25'h100 + 25'(i); ioctl_data = 8'hC0 + 8'(i); ioctl_wr = 1'b1;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    for (int j = 0; j < 4; j++) begin
      chk("ovf_order", prog_if.prog_data, {8'hC0 + 8'(j), 8'hC0 + 8'(j)});
      ack_force = 1'b1;
      @(negedge clk);
    end
    ack_force = 1'b0;
    chk("ovf_drained", prog_if.prog_we, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    chk("ovf_clear", overflow, 1'b0);

    // full FIFO with a simultaneous pop still accepts the push
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ioctl_addr = 25'h200 + 25'(i); ioctl_data = 8'hD0 + 8'(i); ioctl_wr = 1'b1;
    end
    @(negedge clk);
    ioctl_addr = 25'h204; ioctl_data = 8'hD4; ack_force = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0; ack_force = 1'b0;
    chk("fullpop_no_ovf", overflow, 1'b0);
    chk("fullpop_head", prog_if.prog_data, 16'hD1D1);
    ack_force = 1'b1;
    repeat (4) @(negedge clk);
    ack_force = 1'b0;
    chk("fullpop_drained", prog_if.prog_we, 1'b0);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ioctl_addr = 25'h300 + 25'(i); ioctl_data = 8'hE0 + 8'(i); ioctl_wr = 1'b1;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("pre_rst_we", prog_if.prog_we, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_we", prog_if.prog_we, 1'b0);
    chk("async_rst_prom", prom_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", prog_if.prog_we, 1'b0);
    end
    ack_force = 1'b0;

    // randomized traffic against the model
    ack_mode = 1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      downloading = ($urandom_range(0, 31) != 0);
      ioctl_wr    = ($urandom_range(0, 2) != 0);
      ioctl_data  = 8'($urandom_range(0, 255));
      ioctl_addr  = 25'($urandom_range(0, 32'h7F_FFFF));
    end
    @(negedge clk);
    ioctl_wr = 1'b0; downloading = 1'b0;

    cyc = 0;
    while (prog_if.prog_we && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_timeout", (cyc >= 200), 1'b0);
    @(negedge clk);
    chk("final_busy", dwnld_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
